// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter.
// Holds the field widths, the illegal destination code, the tx state enum
// and a helper that forms the header byte from length and destination.
package router_pkg;

   localparam int ADDR_W    = 2;
   localparam int LEN_W     = 6;
   localparam int MAX_LEN   = 63;
   localparam int DATA_W    = 8;
   localparam int BUF_DEPTH = 64;

   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HEADER,
      PAYLOAD,
      PARITY,
      DONE
   } tx_state_e;

   // Header byte carries the payload length in the upper bits and the
   // destination port in the lower bits.
   function automatic logic [DATA_W-1:0] hdr_byte(input logic [LEN_W-1:0]  l,
                                                  input logic [ADDR_W-1:0] a);
      return {l, a};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer for router_pkt_tx.
// 64 x 8 storage, one synchronous write port and one combinational read port.
// Ports:
//   clk        - system clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write index
//   wr_data_i  - write data
//   rd_addr_i  - read index
//   rd_data_o  - read data (combinational)
// Contents are not reset.
module router_tx_buf
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [LEN_W-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [LEN_W-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter.
// Accepts a send request (destination + length), collects the payload into a
// local buffer, then emits header, payload bytes and a trailing XOR parity
// byte toward the router, stalling whenever the router raises busy.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   start      - one-cycle send request (only honoured in IDLE)
//   addr       - destination port 0..2 (3 is rejected)
//   len        - payload length 1..63 (0 is rejected)
//   inj_err    - (only with ROUTER_TX_ERR_INJ_EN) invert parity for this packet
//   pld_data   - payload byte
//   pld_valid  - payload byte valid
//   pld_ready  - high while payload bytes are being accepted
//   busy       - router stall; packet outputs hold while high
//   pkt_valid  - registered packet byte valid (header/payload only)
//   pkt_data   - registered packet byte
//   done       - one-cycle pulse after the parity byte
//   err        - one-cycle pulse on a rejected request
//   idle       - high only in IDLE
//
// Build option: define ROUTER_TX_ERR_INJ_EN to add the inj_err input.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a legal start; illegal start pulses err
// LOAD    | pld_ready high, storing len payload bytes into the buffer
// HEADER  | presenting {len,addr} with pkt_valid
// PAYLOAD | presenting buffer[rd_ptr] with pkt_valid
// PARITY  | presenting the XOR parity byte, pkt_valid low
// DONE    | done pulse, back to IDLE
module router_pkt_tx
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
`ifdef ROUTER_TX_ERR_INJ_EN
   input  logic              inj_err,
`endif
   input  logic [DATA_W-1:0] pld_data,
   input  logic              pld_valid,
   output logic              pld_ready,
   input  logic              busy,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] pkt_data,
   output logic              done,
   output logic              err,
   output logic              idle
);

   tx_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] parity_q, parity_d;
   logic              inj_q, inj_d;
   logic              err_q, err_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [DATA_W-1:0] pkt_data_q, pkt_data_d;

   logic              inj_in;
   logic              start_bad;
   logic              last_wr;
   logic              last_rd;
   logic              buf_we;
   logic [DATA_W-1:0] buf_rd_data;

`ifdef ROUTER_TX_ERR_INJ_EN
   assign inj_in = inj_err;
`else
   assign inj_in = 1'b0;
`endif

   assign start_bad = (len == '0) || (addr == ADDR_ILLEGAL);
   assign last_wr   = (wr_ptr_q == len_q - LEN_W'(1));
   assign last_rd   = (rd_ptr_q == len_q - LEN_W'(1));

   // Read side is addressed with the next pointer so the registered
   // pkt_data already shows the byte belonging to the next state.
   router_tx_buf u_buf (
      .clk       (clk),
      .wr_en_i   (buf_we),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (pld_data),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (buf_rd_data)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      parity_d = parity_q;
      inj_d    = inj_q;
      err_d    = 1'b0;
      buf_we   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = LOAD;
                  addr_d   = addr;
                  len_d    = len;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  parity_d = '0;
                  inj_d    = inj_in;
               end
            end
         end
         LOAD: begin
            if (pld_valid) begin
               buf_we = 1'b1;
               if (last_wr) begin
                  state_d  = HEADER;
                  wr_ptr_d = '0;
               end else begin
                  wr_ptr_d = wr_ptr_q + LEN_W'(1);
               end
            end
         end
         HEADER: begin
            if (!busy) begin
               parity_d = parity_q ^ pkt_data_q;
               rd_ptr_d = '0;
               state_d  = PAYLOAD;
            end
         end
         PAYLOAD: begin
            // pkt_data_q is the byte currently on the bus, so it is the
            // one folded into parity as it is retired.
            if (!busy) begin
               parity_d = parity_q ^ pkt_data_q;
               if (last_rd) begin
                  state_d = PARITY;
               end else begin
                  rd_ptr_d = rd_ptr_q + LEN_W'(1);
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pkt_valid_d = 1'b0;
      pkt_data_d  = '0;
      case (state_d)
         HEADER: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = hdr_byte(len_d, addr_d);
         end
         PAYLOAD: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = buf_rd_data;
         end
         PARITY: begin
            pkt_data_d = parity_d ^ {DATA_W{inj_d}};
         end
         default: begin
            pkt_valid_d = 1'b0;
            pkt_data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         parity_q    <= '0;
         inj_q       <= 1'b0;
         err_q       <= 1'b0;
         pkt_valid_q <= 1'b0;
         pkt_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         parity_q    <= parity_d;
         inj_q       <= inj_d;
         err_q       <= err_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_data_q  <= pkt_data_d;
      end
   end

   assign pkt_valid = pkt_valid_q;
   assign pkt_data  = pkt_data_q;
   assign err       = err_q;
   assign pld_ready = (state_q == LOAD);
   assign done      = (state_q == DONE);
   assign idle      = (state_q == IDLE);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a packet-level reference model
// (queue of expected bus bytes per packet) checked every cycle, directed
// packets with literal expectations, then a randomized phase.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       rst, start, pld_valid, busy, inj_err;
   logic [1:0] addr;
   logic [5:0] len;
   logic [7:0] pld_data;
   logic       pld_ready, pkt_valid, done, err, idle;
   logic [7:0] pkt_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_pkt_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .addr      (addr),
      .len       (len),
`ifdef ROUTER_TX_ERR_INJ_EN
      .inj_err   (inj_err),
`endif
      .pld_data  (pld_data),
      .pld_valid (pld_valid),
      .pld_ready (pld_ready),
      .busy      (busy),
      .pkt_valid (pkt_valid),
      .pkt_data  (pkt_data),
      .done      (done),
      .err       (err),
      .idle      (idle)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // ph: 0 waiting, 1 collecting payload, 2 emitting stream, 3 done pulse
   int         ph = 0;
   int         emit_idx = 0;
   logic [5:0] mlen = '0;
   logic [1:0] maddr = '0;
   logic       minj = 1'b0;
   logic       m_err = 1'b0;
   logic [7:0] m_p;
   logic [7:0] pl[$];
   logic [7:0] stream[$];
   bit         armed = 1'b0;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc++;
      m_err = 1'b0;
      if (rst) begin
         ph = 0;
         armed = 1'b1;
         pl.delete();
      end else begin
         case (ph)
            0: if (start) begin
               if (len == 6'd0 || addr == 2'd3) m_err = 1'b1;
               else begin
                  ph = 1; mlen = len; maddr = addr; minj = inj_err; pl.delete();
               end
            end
            1: if (pld_valid) begin
               pl.push_back(pld_data);
               if (pl.size() == int'(mlen)) begin
                  stream.delete();
                  m_p = {mlen, maddr};
                  stream.push_back(m_p);
                  foreach (pl[i]) begin
                     stream.push_back(pl[i]);
                     m_p = m_p ^ pl[i];
                  end
                  if (minj) m_p = ~m_p;
                  stream.push_back(m_p);
                  emit_idx = 0;
                  ph = 2;
               end
            end
            2: if (!busy) begin
               emit_idx++;
               if (emit_idx == int'(mlen) + 2) ph = 3;
            end
            default: ph = 0;
         endcase
      end
   end

   // ---------------- compare + capture ----------------
   logic [7:0] cap[$];
   logic [7:0] cap_par = '0;
   int         par_cnt = 0, err_cnt = 0, valid_cnt = 0, done_cnt = 0, done_cyc = 0;
   logic       exp_valid;
   logic [7:0] exp_data;

   always @(negedge clk) begin
      if (armed) begin
         exp_valid = (ph == 2) && (emit_idx <= int'(mlen));
         exp_data  = (ph == 2) ? stream[emit_idx] : 8'h00;
         chk("pkt_valid", pkt_valid, exp_valid);
         chk("pkt_data", pkt_data, exp_data);
         chk("idle", idle, ph == 0);
         chk("pld_ready", pld_ready, ph == 1);
         chk("done", done, ph == 3);
         chk("err", err, m_err);
         if (pkt_valid) begin
            cap.push_back(pkt_data);
            valid_cnt++;
         end
         if (!pkt_valid && !idle && !pld_ready && !done) begin
            par_cnt++;
            cap_par = pkt_data;
         end
         if (err) err_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic quiet();
      start = 1'b0; pld_valid = 1'b0; busy = 1'b0; rst = 1'b0; inj_err = 1'b0;
      addr = 2'd0; len = 6'd0; pld_data = 8'd0;
   endtask

   task automatic send(input logic [1:0] a, input logic [5:0] l, input logic [7:0] base,
                       input bit gaps, input logic inj, output int last_cyc);
      @(negedge clk);
      start = 1'b1; addr = a; len = l; inj_err = inj;
      @(negedge clk);
      start = 1'b0; inj_err = 1'b0;
      last_cyc = 0;
      for (int i = 0; i < int'(l); i++) begin
         if (gaps) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
               pld_valid = 1'b0;
               start = 1'($urandom_range(0, 1));
               addr  = 2'($urandom_range(0, 3));
               len   = 6'($urandom_range(0, 63));
               @(negedge clk);
            end
         end
         pld_valid = 1'b1;
         pld_data  = base + 8'(i);
         last_cyc  = cyc;
         @(negedge clk);
      end
      pld_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit pulse_start);
      int n = 0;
      while (!done && n < budget) begin
         if (pulse_start) begin
            start = pkt_valid & 1'($urandom_range(0, 1));
            addr  = 2'($urandom_range(0, 3));
            len   = 6'($urandom_range(0, 63));
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("done_timeout", n < budget, 1'b1);
      @(negedge clk);
   endtask

   task automatic check_seq(input string nm, input logic [7:0] e[$], input logic [7:0] par);
      chk({nm, "_count"}, cap.size(), e.size());
      for (int i = 0; i < e.size(); i++)
         chk({nm, "_byte"}, (i < cap.size()) ? cap[i] : 8'hxx, e[i]);
      chk({nm, "_parity"}, cap_par, par);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int         lc, n, p0, e0, v0, d0;
      logic [7:0] e032[$];
      logic [7:0] e033[$];

      quiet();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_idle", idle, 1'b1);
      chk("rst_pkt_valid", pkt_valid, 1'b0);
      chk("rst_pkt_data", pkt_data, 8'h00);
      chk("rst_pld_ready", pld_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // basic packet
      e032 = {8'h1E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      cap.delete(); p0 = par_cnt;
      send(2'd2, 6'd7, 8'h01, 1'b0, 1'b0, lc);
      wait_done(200, 1'b0);
      check_seq("pkt032", e032, 8'h1E);
      chk("pkt032_latency", done_cyc - lc, 10);
      chk("pkt032_parity_cycles", par_cnt - p0, 1);
      chk("model032_parity", stream[stream.size()-1], 8'h1E);

      // same packet, busy for 3 cycles while 0x03 is on the bus
      e033 = {8'h1E, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      cap.delete();
      send(2'd2, 6'd7, 8'h01, 1'b0, 1'b0, lc);
      n = 0;
      while (!(pkt_valid && pkt_data == 8'h03) && n < 100) begin
         @(negedge clk); n++;
      end
      chk("busy_wait_timeout", n < 100, 1'b1);
      busy = 1'b1;
      repeat (3) @(negedge clk);
      busy = 1'b0;
      wait_done(200, 1'b0);
      check_seq("pkt033", e033, 8'h1E);
      chk("pkt033_latency", done_cyc - lc, 13);

      // gaps in payload and ignored start pulses
      cap.delete();
      send(2'd2, 6'd7, 8'h01, 1'b1, 1'b0, lc);
      wait_done(200, 1'b1);
      check_seq("pkt037", e032, 8'h1E);

      // illegal requests
      e0 = err_cnt; v0 = valid_cnt;
      @(negedge clk); start = 1'b1; len = 6'd0; addr = 2'd1;
      @(negedge clk); start = 1'b0;
      chk("err_len0", err, 1'b1);
      chk("idle_len0", idle, 1'b1);
      @(negedge clk); start = 1'b1; len = 6'd5; addr = 2'd3;
      @(negedge clk); start = 1'b0;
      chk("err_addr3", err, 1'b1);
      chk("idle_addr3", idle, 1'b1);
      repeat (3) @(negedge clk);
      chk("err_pulses", err_cnt - e0, 2);
      chk("err_no_valid", valid_cnt - v0, 0);

      // reset mid-payload, then a fresh packet
      send(2'd1, 6'd5, 8'h10, 1'b0, 1'b0, lc);
      n = 0;
      while (!(pkt_valid && pkt_data == 8'h12) && n < 100) begin
         @(negedge clk); n++;
      end
      chk("rst_wait_timeout", n < 100, 1'b1);
      p0 = par_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_pkt_valid", pkt_valid, 1'b0);
      chk("midrst_idle", idle, 1'b1);
      repeat (3) @(negedge clk);
      chk("midrst_no_parity", par_cnt - p0, 0);
      cap.delete();
      send(2'd0, 6'd1, 8'hFF, 1'b0, 1'b0, lc);
      wait_done(100, 1'b0);
      check_seq("pkt035", '{8'h04, 8'hFF}, 8'hFB);

`ifdef ROUTER_TX_ERR_INJ_EN
      cap.delete();
      send(2'd1, 6'd1, 8'hAA, 1'b0, 1'b1, lc);
      wait_done(100, 1'b0);
      check_seq("pkt036", '{8'h05, 8'hAA}, 8'h50);
`endif

      // randomized traffic
      d0 = done_cnt;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 399) == 0);
         start     = ($urandom_range(0, 5) == 0);
         addr      = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) len = 6'd0;
         else if ($urandom_range(0, 7) == 0) len = 6'($urandom_range(1, 63));
         else len = 6'($urandom_range(1, 8));
         pld_valid = ($urandom_range(0, 3) != 0);
         pld_data  = 8'($urandom);
         busy      = ($urandom_range(0, 3) == 0);
`ifdef ROUTER_TX_ERR_INJ_EN
         inj_err   = 1'($urandom_range(0, 1));
`else
         inj_err   = 1'b0;
`endif
      end
      quiet();
      repeat (5) @(negedge clk);
      chk("random_packets_completed", done_cnt - d0 > 10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port start  input  1  one-cycle request to send a packet.
REQ-004 SHALL have port addr  input  2  destination port 0..2; 3 is illegal.
REQ-005 SHALL have port len  input  6  payload length 1..63; 0 is illegal.
REQ-006 SHALL have ports pld_data  input  8  and pld_valid  input  1  for user payload bytes.
REQ-007 SHALL have port pld_ready  output  1  high when a payload byte is accepted.
REQ-008 SHALL have port busy  input  1  router stall; outputs are held while high.
REQ-009 SHALL have ports pkt_valid  output  1  and pkt_data  output  8  to drive the router input.
REQ-010 SHALL have ports done  output  1  (one-cycle pulse), err  output  1  (one-cycle pulse) and idle  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE.
REQ-012 In IDLE with start=1, len!=0 and addr!=3, SHALL latch addr/len, clear parity, and go to LOAD.
REQ-013 In IDLE with start=1 and (len==0 or addr==3), SHALL pulse err next cycle and stay IDLE.
REQ-014 SHALL ignore start in any state other than IDLE.
REQ-015 In LOAD, pld_ready=1 and each pld_valid beat stores to buffer[wr_ptr]; after the len-th beat SHALL go to HEADER.
REQ-016 A pld_valid gap in LOAD SHALL just wait, with no timeout.
REQ-017 HEADER: pkt_valid=1, pkt_data={len,addr}; parity^=header on leaving HEADER.
REQ-018 PAYLOAD: pkt_valid=1, pkt_data=buffer[rd_ptr]; parity^=byte on each advance; after len bytes SHALL go to PARITY.
REQ-019 PARITY: pkt_valid=0, pkt_data=XOR of header and all payload bytes.
REQ-020 The states HEADER, PAYLOAD and PARITY SHALL advance only on an edge where busy=0; with busy=1, pkt_valid and pkt_data SHALL hold stable.
REQ-021 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-022 idle SHALL be 1 only in IDLE; pkt_valid/pkt_data SHALL be registered outputs.
REQ-023 Without busy, the latency from the last LOAD beat SHALL be: header next cycle, len payload cycles, 1 parity cycle, then done.
REQ-024 The pointers SHALL be 6-bit and count 0..len-1, with no wrap beyond len.
REQ-025 pkt_data SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-026 rst=1 at any edge, including mid-packet, SHALL force IDLE, pointers and parity to 0, and pkt_valid=0, pkt_data=0, pld_ready=0, done=0, err=0, idle=1.
REQ-027 Buffer contents need not be reset; a partial packet SHALL be discarded without emitting a parity byte.

Configuration
REQ-028 With ROUTER_TX_ERR_INJ_EN defined, SHALL add input inj_err (1 bit), sampled when start is accepted; if set, the parity byte SHALL be bitwise inverted.
REQ-029 Without ROUTER_TX_ERR_INJ_EN, the inj_err port SHALL be absent and parity SHALL always be correct.

Structure
REQ-030 Shared package router_pkg SHALL hold ADDR_W=2, LEN_W=6, MAX_LEN=63, ADDR_ILLEGAL=2'b11 and the tx state enum.
REQ-031 Sub-module router_tx_buf SHALL be a 64x8 buffer with one synchronous write and one combinational read, instantiated once.

Verification
REQ-032 addr=2, len=7, payload 01..07, busy=0 -> header 0x1E, bytes 01..07 with pkt_valid=1, parity 0x1E with pkt_valid=0, then done.
REQ-033 Same packet with busy=1 for 3 cycles while byte 0x03 is shown -> 0x03 held for 4 cycles; total adds 3 cycles; parity still 0x1E.
REQ-034 start with len=0, then start with addr=3 -> err pulse each time, idle stays 1, pkt_valid never asserts.
REQ-035 rst during PAYLOAD after byte 2 -> next cycle pkt_valid=0 and idle=1; a new len=1, addr=0, payload 0xFF packet -> header 0x04, then 0xFF, then parity 0xFB.
REQ-036 ROUTER_TX_ERR_INJ_EN with inj_err=1, addr=1, len=1, payload 0xAA -> header 0x05, then 0xAA, then parity ~0xAF=0x50.
REQ-037 pld_valid gaps in LOAD plus start pulses mid-packet -> the gaps only stretch LOAD, the start pulses are ignored, and the output sequence is unchanged.
